// File: rtl/shift_reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl_pkg
// Purpose  : Shared controller state encoding and shift-register mode codes.
// Revision : 1.0 - initial release
// ============================================================================
package shift_reg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        RX_OUT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? MODE_SHL : MODE_SHR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl_if
// Purpose  : Transmit/receive client handshake bundle for shift_reg_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_reg_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_dir;
    logic             rx_req;
    logic             rx_dir;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, tx_dir, rx_req, rx_dir, rx_ready,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, tx_dir, rx_req, rx_dir, rx_ready,
        output tx_ready, rx_valid, rx_data
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter; requester 0 wins after reset.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en,
    input  wire logic [1:0] req,
    output logic      [1:0] gnt
);
    // Set means requester 1 was granted last, so requester 0 has priority.
    logic r_last1;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_last1 ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last1 <= 1'b1;
        end else if (|gnt) begin
            r_last1 <= gnt[1];
        end
    end
endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : WIDTH-bit universal shift register (hold / shr / shl / load).
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [1:0]       mode,
    input  wire logic [WIDTH-1:0] d,
    input  wire logic             ser_in,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;

    // Right shift enters at the MSB, left shift enters at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHR:  r_q <= {ser_in, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], ser_in};
                MODE_LOAD: r_q <= d;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl
// Purpose  : Sequences a universal shift register for tx and rx clients.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             bit_tick,
    input  wire logic             abort,
    shift_reg_ctrl_if.slave       bus,
    output logic                  sr_en,
    output logic      [1:0]       sr_mode,
    output logic      [WIDTH-1:0] sr_d,
    input  wire logic [WIDTH-1:0] sr_q,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_is_rx;
    logic [WIDTH-1:0] r_word;
    logic [1:0]       w_gnt;
    logic             w_abort;
    logic             w_tx_ready;
    logic             w_rx_valid;
    logic [WIDTH-1:0] w_rx_data;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (r_state == IDLE),
        .req ({bus.rx_req, bus.tx_valid}),
        .gnt (w_gnt)
    );

    assign w_abort = abort && (r_state != IDLE);

    always_comb begin
        w_next     = r_state;
        sr_en      = 1'b0;
        sr_mode    = MODE_HOLD;
        w_tx_ready = 1'b0;
        w_rx_valid = 1'b0;
        w_rx_data  = '0;
        frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_ready = w_gnt[0];
                if (w_gnt[0])      w_next = LOAD;
                else if (w_gnt[1]) w_next = SHIFT;
            end
            LOAD: begin
                sr_en   = 1'b1;
                sr_mode = MODE_LOAD;
                w_next  = SHIFT;
            end
            SHIFT: begin
                if (bit_tick) begin
                    sr_en   = 1'b1;
                    sr_mode = shift_mode(r_dir);
                    if (r_cnt == CNT_W'(1)) w_next = r_is_rx ? RX_OUT : DONE;
                end
            end
            RX_OUT: begin
                w_rx_valid = 1'b1;
                w_rx_data  = sr_q;
                if (bus.rx_ready) w_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // An aborted frame neither touches the register nor reports completion.
        if (w_abort) begin
            w_next     = IDLE;
            sr_en      = 1'b0;
            sr_mode    = MODE_HOLD;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_is_rx <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            if (w_abort) begin
                r_cnt <= '0;
            end else if (w_gnt[0]) begin
                r_word  <= bus.tx_data;
                r_dir   <= bus.tx_dir;
                r_cnt   <= CNT_W'(WIDTH);
                r_is_rx <= 1'b0;
            end else if (w_gnt[1]) begin
                r_dir   <= bus.rx_dir;
                r_cnt   <= CNT_W'(WIDTH);
                r_is_rx <= 1'b1;
            end else if (r_state == SHIFT && bit_tick) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign sr_d         = r_word;
    assign busy         = (r_state != IDLE);
    assign bus.tx_ready = w_tx_ready;
    assign bus.rx_valid = w_rx_valid;
    assign bus.rx_data  = w_rx_data;
endmodule
`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_ctrl
// Purpose  : Self-checking bench: frame-level reference model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_ctrl;
    import shift_reg_ctrl_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, bit_tick = 1'b0, abort = 1'b0, ser_in = 1'b0;
    logic         tx_valid = 1'b0, tx_dir = 1'b0, rx_req = 1'b0, rx_dir = 1'b0, rx_ready = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_ready, rx_valid, sr_en, busy, frame_done;
    logic [W-1:0] rx_data, sr_d, sr_q;
    logic [1:0]   sr_mode;

    int checks = 0;
    int failures = 0;

    shift_reg_ctrl_if #(.WIDTH(W)) bif ();
    assign bif.tx_valid = tx_valid;
    assign bif.tx_data  = tx_data;
    assign bif.tx_dir   = tx_dir;
    assign bif.rx_req   = rx_req;
    assign bif.rx_dir   = rx_dir;
    assign bif.rx_ready = rx_ready;
    assign tx_ready     = bif.tx_ready;
    assign rx_valid     = bif.rx_valid;
    assign rx_data      = bif.rx_data;

    shift_reg_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bit_tick(bit_tick), .abort(abort), .bus(bif.slave),
        .sr_en(sr_en), .sr_mode(sr_mode), .sr_d(sr_d), .sr_q(sr_q),
        .busy(busy), .frame_done(frame_done)
    );

    univ_shift_reg #(.WIDTH(W)) u_sr (
        .clk(clk), .rst(rst), .en(sr_en), .mode(sr_mode), .d(sr_d),
        .ser_in(ser_in), .q(sr_q)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // owner: 0 none, 1 tx, 2 rx; bits_left counts remaining shifts of the frame.
    bit           mv = 0, n_mv = 0;
    int           m_owner = 0, n_owner = 0, m_left = 0, n_left = 0;
    bit           m_load = 0, n_load = 0, m_pres = 0, n_pres = 0, m_fin = 0, n_fin = 0;
    bit           m_last_rx = 1, n_last_rx = 1, m_dir = 0, n_dir = 0;
    logic [W-1:0] m_word = '0, n_word = '0, m_sr = '0, n_sr = '0;

    always @(negedge clk) begin : p_model
        logic       e_idle, e_txw, e_rxw, e_abort, e_en, e_fd;
        logic [1:0] e_mode;
        e_idle  = (m_owner == 0);
        e_txw   = e_idle && tx_valid && (!rx_req || m_last_rx);
        e_rxw   = e_idle && rx_req && !e_txw;
        e_abort = abort && !e_idle;
        e_en    = 1'b0;
        e_mode  = MODE_HOLD;
        if (!e_abort) begin
            if (m_load) begin
                e_en = 1'b1; e_mode = MODE_LOAD;
            end else if (!e_idle && m_left > 0 && bit_tick) begin
                e_en = 1'b1; e_mode = m_dir ? MODE_SHL : MODE_SHR;
            end
        end
        e_fd = m_fin && !e_abort;
        if (mv) begin
            chk("tx_ready",   32'(tx_ready),   32'(e_txw));
            chk("sr_en",      32'(sr_en),      32'(e_en));
            chk("sr_mode",    32'(sr_mode),    32'(e_mode));
            chk("sr_d",       32'(sr_d),       32'(m_word));
            chk("busy",       32'(busy),       32'(!e_idle));
            chk("rx_valid",   32'(rx_valid),   32'(m_pres));
            chk("rx_data",    32'(rx_data),    m_pres ? 32'(m_sr) : 32'd0);
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("sr_q",       32'(sr_q),       32'(m_sr));
        end
        n_mv = mv; n_owner = m_owner; n_left = m_left; n_load = m_load; n_pres = m_pres;
        n_fin = m_fin; n_last_rx = m_last_rx; n_dir = m_dir; n_word = m_word; n_sr = m_sr;
        if (rst) begin
            n_mv = 1; n_owner = 0; n_left = 0; n_load = 0; n_pres = 0; n_fin = 0;
            n_last_rx = 1; n_dir = 0; n_word = '0; n_sr = '0;
        end else if (mv) begin
            if (e_abort) begin
                n_owner = 0; n_load = 0; n_pres = 0; n_fin = 0; n_left = 0;
            end else if (e_idle) begin
                if (e_txw) begin
                    n_owner = 1; n_word = tx_data; n_dir = tx_dir; n_load = 1; n_left = W; n_last_rx = 0;
                end else if (e_rxw) begin
                    n_owner = 2; n_dir = rx_dir; n_left = W; n_last_rx = 1;
                end
            end else if (m_load) begin
                n_load = 0;
            end else if (m_left > 0) begin
                if (bit_tick) begin
                    n_left = m_left - 1;
                    if (n_left == 0) begin
                        if (m_owner == 2) n_pres = 1; else n_fin = 1;
                    end
                end
            end else if (m_pres) begin
                if (rx_ready) begin n_pres = 0; n_fin = 1; end
            end else if (m_fin) begin
                n_fin = 0; n_owner = 0;
            end
            if (e_en) begin
                if (e_mode == MODE_LOAD)     n_sr = m_word;
                else if (e_mode == MODE_SHR) n_sr = (m_sr >> 1) | (W'(ser_in) << (W - 1));
                else                         n_sr = W'((m_sr << 1) | W'(ser_in));
            end
        end
    end

    always @(posedge clk) begin
        mv <= n_mv; m_owner <= n_owner; m_left <= n_left; m_load <= n_load; m_pres <= n_pres;
        m_fin <= n_fin; m_last_rx <= n_last_rx; m_dir <= n_dir; m_word <= n_word; m_sr <= n_sr;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tx(input logic [W-1:0] w, input logic d, input int per,
                          output int shifts, output bit done, output int bad);
        bit acc;
        shifts = 0; done = 0; bad = 0; acc = 0;
        step();
        tx_valid = 1'b1; tx_data = w; tx_dir = d;
        for (int n = 0; n < 60 && !done; n++) begin
            bit_tick = (per == 1) || (n % per == 1);
            @(negedge clk);
            if (tx_valid && tx_ready) acc = 1;
            if (sr_en && sr_mode == (d ? MODE_SHL : MODE_SHR)) begin
                shifts++;
                if (!bit_tick) bad++;
            end
            if (frame_done) done = 1;
            step();
            if (acc) tx_valid = 1'b0;
        end
        bit_tick = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit seen;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (!busy) seen = 1;
            else step();
        end
        chk(nm, 32'(seen), 32'd1);
        step();
    endtask

    initial begin : p_stim
        int          shifts, bad, g;
        bit          done, seen, acc;
        logic [3:0]  pat;
        int          grants[6];
        int          exp4[6];
        exp4 = '{0, 1, 0, 1, 0, 0};

        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_sr_d", 32'(sr_d), 0);
        chk("reset_outs", {27'd0, tx_ready, rx_valid, sr_en, frame_done, |rx_data}, 0);

        // Frame timing with bit_tick held high
        step();
        tx_valid = 1'b1; tx_data = 4'b1011; tx_dir = 1'b0; bit_tick = 1'b1;
        @(negedge clk); chk("t1_accept", 32'(tx_ready), 1);
        step(); tx_valid = 1'b0;
        @(negedge clk);
        chk("t1_load_mode", {30'd0, sr_mode}, 32'd3);
        chk("t1_load_d", 32'(sr_d), 32'hB);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            chk("t1_shift", {29'd0, sr_en, sr_mode}, 32'b101);
        end
        step(); @(negedge clk); chk("t1_done", 32'(frame_done), 1);
        step(); @(negedge clk); chk("t1_idle", 32'(busy), 0);
        chk("t1_shifted_out", 32'(sr_q), 0);
        bit_tick = 1'b0;

        // Sparse ticks, one falling in the load cycle
        run_tx(4'b1011, 1'b0, 3, shifts, done, bad);
        chk("t2_shifts", 32'(shifts), 4);
        chk("t2_done", 32'(done), 1);
        chk("t2_untimed_shift", 32'(bad), 0);

        // Receive frame, MSB first, consumer stalls
        rx_req = 1'b1; rx_dir = 1'b1; bit_tick = 1'b1; rx_ready = 1'b0;
        pat = 4'b1101;
        @(negedge clk); chk("t3_grant_no_txready", 32'(tx_ready), 0);
        for (int i = 0; i < 4; i++) begin
            step(); rx_req = 1'b0; ser_in = pat[3-i];
            @(negedge clk); chk("t3_shift", {29'd0, sr_en, sr_mode}, 32'b110);
        end
        for (int i = 0; i < 5; i++) begin
            step(); @(negedge clk);
            chk("t3_rx_valid", 32'(rx_valid), 1);
            chk("t3_rx_data", 32'(rx_data), 32'hD);
            chk("t3_rx_hold", 32'(sr_en), 0);
        end
        step(); rx_ready = 1'b1;
        @(negedge clk); chk("t3_handshake", 32'(rx_valid), 1);
        step(); rx_ready = 1'b0;
        @(negedge clk); chk("t3_done", 32'(frame_done), 1);
        step(); bit_tick = 1'b0; ser_in = 1'b0;

        // Round-robin from reset
        rst = 1'b1; step(); rst = 1'b0;
        tx_valid = 1'b1; rx_req = 1'b1; rx_ready = 1'b1; bit_tick = 1'b1; tx_data = 4'b0101;
        g = 0;
        for (int c = 0; c < 200 && g < 6; c++) begin
            @(negedge clk);
            if (!busy) begin grants[g] = tx_ready ? 0 : 1; g++; end
            step();
            if (g == 5) rx_req = 1'b0;
        end
        tx_valid = 1'b0; rx_req = 1'b0;
        chk("t4_grant_count", 32'(g), 6);
        for (int k = 0; k < 6 && k < g; k++) chk("t4_grant_order", 32'(grants[k]), 32'(exp4[k]));
        wait_idle("t4_idle");
        rx_ready = 1'b0;

        // Abort after two shifts
        tx_valid = 1'b1; tx_data = 4'b0110; tx_dir = 1'b1; bit_tick = 1'b1;
        @(negedge clk); chk("t5_accept", 32'(tx_ready), 1);
        step(); tx_valid = 1'b0;
        step(); step();
        step(); abort = 1'b1; bit_tick = 1'b0;
        @(negedge clk); chk("t5_abort_no_done", 32'(frame_done), 0);
        step(); abort = 1'b0;
        @(negedge clk);
        chk("t5_idle", 32'(busy), 0);
        chk("t5_no_done", 32'(frame_done), 0);
        run_tx(4'b1001, 1'b0, 1, shifts, done, bad);
        chk("t5_next_shifts", 32'(shifts), 4);
        chk("t5_next_done", 32'(done), 1);

        // Reset while presenting received data
        rx_req = 1'b1; rx_dir = 1'b0; bit_tick = 1'b1; rx_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (rx_valid) seen = 1;
            step(); rx_req = 1'b0;
        end
        chk("t6_reached_rx_out", 32'(seen), 1);
        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("t6_outs_zero", {21'd0, busy, tx_ready, rx_valid, sr_en, frame_done, sr_mode, |rx_data, |sr_d}, 0);
        step(); tx_valid = 1'b1; rx_req = 1'b1;
        @(negedge clk); chk("t6_tx_first", 32'(tx_ready), 1);
        step(); tx_valid = 1'b0; rx_req = 1'b0;
        wait_idle("t6_idle");

        // Randomized traffic against the reference model
        acc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = tx_valid && tx_ready;
            step();
            rst = ($urandom_range(0, 299) == 0);
            if (!tx_valid || acc) begin
                tx_valid = ($urandom_range(0, 2) == 0);
                tx_data  = W'($urandom);
                tx_dir   = 1'($urandom);
            end
            rx_req   = ($urandom_range(0, 3) == 0);
            rx_dir   = 1'($urandom);
            bit_tick = 1'($urandom);
            abort    = ($urandom_range(0, 39) == 0);
            rx_ready = ($urandom_range(0, 2) == 0);
            ser_in   = 1'($urandom);
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Sequencing controller for the team's WIDTH-bit universal shift register (mode 00 hold, 01 right shift, 10 left shift, 11 parallel load). It serves two requesters over one register:
- a transmit client that hands over a parallel word to be loaded and shifted out serially;
- a receive client that requests WIDTH serial bits be shifted in and returned as a parallel word.
Bit timing comes from an external bit_tick strobe. Requesters are arbitrated round-robin.

Parameters:
WIDTH, 4, shift register width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), bit counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
bit_tick  in  1  shift strobe; one register shift per tick while shifting
abort  in  1  synchronous abort of current frame
tx_valid  in  1  transmit word offered (held until accepted)
tx_ready  out  1  transmit word accepted this cycle when tx_valid&&tx_ready
tx_data  in  WIDTH  word to transmit
tx_dir  in  1  0 = right shift (LSB first), 1 = left shift (MSB first)
rx_req  in  1  receive frame requested (level; may be withdrawn before grant)
rx_dir  in  1  0 = right shift, 1 = left shift
rx_valid  out  1  received word available
rx_ready  in  1  consumer accepts word
rx_data  out  WIDTH  received word
sr_en  out  1  shift register enable
sr_mode  out  2  shift register mode
sr_d  out  WIDTH  shift register parallel load data
sr_q  in  WIDTH  shift register parallel output
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on frame completion

Behaviour:
- Reset: state IDLE, grant pointer = tx-priority, counter 0, latched dir 0, sr_d 0. All outputs 0.
- States: IDLE, LOAD, SHIFT, RX_OUT, DONE.
- Default outputs in every state: sr_en=0, sr_mode=00.
- IDLE, arbitration:
  - Candidates are tx_valid and rx_req.
  - If only one is present, it wins.
  - If both are present, the non-last-granted client wins; after reset, tx wins.
  - tx win: tx_ready=1 combinationally this cycle; latch tx_data into sr_d and tx_dir; load counter=WIDTH; next state LOAD.
  - rx win: latch rx_dir; load counter=WIDTH; next state SHIFT.
  - The grant pointer updates on each grant.
- LOAD (1 cycle): sr_en=1, sr_mode=11, sr_d=latched word; next state SHIFT. A bit_tick in this cycle is ignored.
- SHIFT:
  - On a cycle with bit_tick=1: sr_en=1, sr_mode=(dir?10:01), counter decrements.
  - Ticks with no shift are not counted.
  - When the tick brings the counter 1 -> 0: tx frame goes to DONE; rx frame goes to RX_OUT.
- RX_OUT:
  - rx_valid=1, rx_data=sr_q; sr_en stays 0, so data is stable.
  - rx_valid stays high with constant data until rx_ready.
  - On rx_valid&&rx_ready: next state DONE.
- DONE (1 cycle): frame_done=1; next state IDLE. No grant is made in DONE.
- rx_data is 0 outside RX_OUT. tx_ready is 0 outside an IDLE tx grant.
- abort:
  - In any non-IDLE state, next state is IDLE, counter cleared, no frame_done.
  - rx_valid drops next cycle; the grant pointer keeps its update.
  - abort in IDLE has no effect.
  - abort has priority over a completing tick or an rx handshake in the same cycle.
- rst mid-operation behaves as reset: immediate return to reset values, and the grant pointer returns to tx-priority.
- Timing: tx frame with bit_tick held high takes WIDTH+3 cycles from accept to IDLE.

Decomposition:
- Shared package: state enum (IDLE, LOAD, SHIFT, RX_OUT, DONE) and mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11, used by both this block and the shift register.
- Submodule: rr_arb2 (two-requester round-robin arbiter with a last-grant flop).
- The bench instantiates the real shift register against sr_* ports.

Test Plan:
1. WIDTH=4, bit_tick=1, tx_valid with tx_data=4'b1011, tx_dir=0:
   - cycle0 tx_ready=1;
   - cycle1 sr_mode=11, sr_d=1011;
   - cycles2-5 sr_en=1, sr_mode=01;
   - cycle6 frame_done=1;
   - cycle7 busy=0.
2. Same word with bit_tick every 3rd cycle, including a tick during LOAD -> exactly 4 shift strobes, each coincident with a SHIFT-state tick; the LOAD tick is not counted.
3. rx_req, rx_dir=1, serial input 1,1,0,1 into the shift register, rx_ready low for 5 cycles -> rx_valid=1 with rx_data=4'b1101 stable throughout and sr_en=0; then accept -> frame_done pulse.
4. tx_valid and rx_req both asserted continuously from reset -> grant order tx, rx, tx, rx; rx_req withdrawn before grant -> tx granted again.
5. abort after 2 ticks in SHIFT -> IDLE next cycle, no frame_done, busy=0; the following tx frame completes with 4 shifts.
6. rst asserted during RX_OUT -> all outputs 0 next cycle; simultaneous tx_valid/rx_req then grants tx first.
